// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state type and opcode classification for the multi-cycle ALU.
package alu_mc_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_SLT   = 4'b0111;
   localparam logic [3:0] ALU_MULT  = 4'b1000;
   localparam logic [3:0] ALU_MULTU = 4'b1001;
   localparam logic [3:0] ALU_DIV   = 4'b1010;
   localparam logic [3:0] ALU_DIVU  = 4'b1011;
   localparam logic [3:0] ALU_NOR   = 4'b1100;
   localparam logic [3:0] ALU_XOR   = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_FIX,
      ST_DONE
   } state_e;

   // mult/multu/div/divu all live in the 10xx block; bit 1 selects divide,
   // bit 0 selects the unsigned variant.
   function automatic logic is_multicycle(input logic [3:0] op);
      return op[3:2] == 2'b10;
   endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per cycle.
// Operands are magnitudes; sign handling is done by the caller.
module alu_muldiv_iter
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] mag_a,
   input  logic [WIDTH-1:0] mag_b,
   output logic             done,
   output logic [WIDTH-1:0] raw_hi,
   output logic [WIDTH-1:0] raw_lo
);

   // hi holds the accumulator (mult) or partial remainder (div);
   // lo holds the shifting multiplier (mult) or dividend/quotient (div).
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
   logic             div_q, div_d, busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   prod_sum, div_shift, div_diff;

   // done is high during the final step so the caller leaves ITER as it lands
   assign done   = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign raw_hi = hi_q;
   assign raw_lo = lo_q;

   // One iteration step, or load on start
   always_comb begin
      prod_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_q};
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      div_d     = div_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      if (start) begin
         hi_d   = '0;
         lo_d   = mag_a;
         b_d    = mag_b;
         div_d  = is_div;
         busy_d = 1'b1;
         cnt_d  = '0;
      end else if (busy_q) begin
         if (div_q) begin
            // Restoring step: keep the trial subtraction only if it did not borrow
            if (!div_diff[WIDTH]) begin
               hi_d = div_diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_shift[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            {hi_d, lo_d} = {prod_sum, lo_q[WIDTH-1:1]};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (done) busy_d = 1'b0;
      end
   end

   // Iteration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         b_q    <= '0;
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         b_q    <= b_d;
         div_q  <= div_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready handshake FSM, single-cycle ops, and sign
// fix-up around the iterative multiply/divide core.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div_by_zero
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_e state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic ovf_q, ovf_d, dbz_q, dbz_d;
   logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, min_ovf_q, min_ovf_d;

   logic accept, op_mc, op_div, op_signed, div_zero, sign_a, sign_b, start, iter_done;
   logic [WIDTH-1:0] mag_a, mag_b, raw_hi, raw_lo, sc_lo, sum, diff;
   logic sc_ovf;
   logic [2*WIDTH-1:0] prod_neg;

   // Request decode: classify the op and form operand magnitudes for the core
   always_comb begin
      accept    = in_valid && in_ready;
      op_mc     = is_multicycle(alu_op);
      op_div    = alu_op[1];
      op_signed = ~alu_op[0];
      div_zero  = op_mc && op_div && (b == '0);
      sign_a    = op_mc && op_signed && a[WIDTH-1];
      sign_b    = op_mc && op_signed && b[WIDTH-1];
      mag_a     = sign_a ? -a : a;
      mag_b     = sign_b ? -b : b;
      start     = accept && op_mc && !div_zero;
   end

   // Single-cycle operations; unknown codes yield 0 with no flags
   always_comb begin
      sum    = a + b;
      diff   = a - b;
      sc_lo  = '0;
      sc_ovf = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            sc_lo  = sum;
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            sc_lo  = diff;
            sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND:  sc_lo = a & b;
         ALU_OR:   sc_lo = a | b;
         ALU_NOR:  sc_lo = ~(a | b);
         ALU_XOR:  sc_lo = a ^ b;
         ALU_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, a < b};
         default:  ;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .is_div (op_div),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .done   (iter_done),
      .raw_hi (raw_hi),
      .raw_lo (raw_lo)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; divide by zero bypasses the iteration entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = start ? ST_ITER : ST_DONE;
         ST_ITER: if (iter_done) state_d = ST_FIX;
         ST_FIX:  state_d = ST_DONE;
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs; zero is gated so it reads 0 whenever no result is presented
   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      out_valid   = (state_q == ST_DONE);
      result_lo   = lo_q;
      result_hi   = hi_q;
      ovf         = ovf_q;
      div_by_zero = dbz_q;
      zero        = out_valid && (lo_q == '0);
   end

   // Result registers: load on accept (single-cycle / div-by-zero) or in FIX
   always_comb begin
      prod_neg  = -{raw_hi, raw_lo};
      lo_d      = lo_q;
      hi_d      = hi_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;
      div_d     = div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      min_ovf_d = min_ovf_q;
      if (accept) begin
         if (div_zero) begin
            lo_d  = '1;
            hi_d  = a;
            ovf_d = 1'b0;
            dbz_d = 1'b1;
         end else if (!op_mc) begin
            lo_d  = sc_lo;
            hi_d  = '0;
            ovf_d = sc_ovf;
            dbz_d = 1'b0;
         end else begin
            // Quotient/product sign is the xor of operand signs; remainder follows a
            div_d     = op_div;
            neg_lo_d  = sign_a ^ sign_b;
            neg_hi_d  = sign_a;
            min_ovf_d = op_div && op_signed && (a == MIN_VAL) && (b == '1);
            dbz_d     = 1'b0;
         end
      end else if (state_q == ST_FIX) begin
         if (div_q) begin
            lo_d  = neg_lo_q ? -raw_lo : raw_lo;
            hi_d  = neg_hi_q ? -raw_hi : raw_hi;
            ovf_d = min_ovf_q;
         end else begin
            {hi_d, lo_d} = neg_lo_q ? prod_neg : {raw_hi, raw_lo};
            ovf_d        = 1'b0;
         end
      end
   end

   // Result and sign-tracking registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q      <= '0;
         hi_q      <= '0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
         div_q     <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         min_ovf_q <= 1'b0;
      end else begin
         lo_q      <= lo_d;
         hi_q      <= hi_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
         div_q     <= div_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         min_ovf_q <= min_ovf_d;
      end
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle integer ALU in the MIPS execute stage.
- Retains the existing 4-bit ALUOp encoding and single-cycle operations.
- Adds iterative signed/unsigned multiply and divide with a 2*WIDTH HI/LO result, plus overflow and divide-by-zero flags.
- Uses valid/ready handshakes so the pipeline can stall on long operations.

Parameters:
WIDTH, 32, operand/result width; legal for any value >= 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block accepts a request this cycle
alu_op  in  4  operation code
a  in  WIDTH  operand A (rs)
b  in  WIDTH  operand B (rt/imm)
out_valid  out  1  result valid
out_ready  in  1  consumer takes the result this cycle
result_lo  out  WIDTH  result, or LO (product low / quotient)
result_hi  out  WIDTH  HI (product high / remainder); 0 for single-cycle ops
zero  out  1  result_lo == 0
ovf  out  1  signed overflow
div_by_zero  out  1  divide with b == 0

Behaviour:
- Opcodes:
  - Single-cycle: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 1101 xor, 0111 slt (signed), 0011 sltu.
  - Multi-cycle: 1000 mult (signed), 1001 multu, 1010 div (signed), 1011 divu.
  - Any other code: single-cycle, result 0, all flags 0.
- A request is accepted when in_valid && in_ready. a, b and alu_op are captured on accept; input changes after accept have no effect.
- FSM states: IDLE, ITER, FIX, DONE. in_ready = (state == IDLE).
- IDLE, single-cycle op accepted: compute and register the result, go to DONE. out_valid rises the cycle after accept (latency 1).
- IDLE, mult/div accepted: latch operand magnitudes and result signs, clear counter, go to ITER.
- ITER: one shift-add (mult) or restoring shift-subtract (div) step per cycle for WIDTH cycles, then go to FIX.
- FIX: apply sign correction (negate the product; quotient sign = sign(a) ^ sign(b); remainder takes the sign of a), then go to DONE. Latency from accept to out_valid is WIDTH+2; the unsigned variants use the same path and latency.
- DONE: out_valid = 1. All outputs hold stable until out_ready = 1, then go to IDLE. The next accept is possible the following cycle. There is no accept while in DONE.
- add/sub:
  - Results wrap modulo 2^WIDTH.
  - add ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
  - sub ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - slt is computed correctly across overflow.
  - ovf = 0 for all other single-cycle ops and for multu/divu/mult.
- Divide by zero, div or divu with b == 0: skip ITER and go to DONE on the next cycle. result_lo = all ones, result_hi = a, div_by_zero = 1.
- Signed div of MIN / -1: result_lo = MIN, result_hi = 0, ovf = 1, normal latency.
- zero is derived from the registered result_lo and is valid only while out_valid = 1.
- Reset: asynchronous, any state. Go to IDLE; out_valid, result_lo, result_hi, zero, ovf and div_by_zero all become 0, and in_ready = 1 immediately. An operation in flight is discarded and nothing is output for it.
- Back-to-back: throughput is one op per 2 cycles (single-cycle) or WIDTH+3 cycles (mult/div) with out_ready held high.

Decomposition:
- Package alu_mc_pkg holds:
  - the 4-bit opcode localparams (ALU_ADD … ALU_DIVU);
  - the FSM state enum;
  - a function is_multicycle(op).
- Natural sub-module alu_muldiv_iter:
  - owns the WIDTH-step iteration datapath (remainder/accumulator, shift register, counter);
  - interface: start, is_div, mag_a, mag_b, step done, raw hi/lo.
- The top level owns the handshake FSM, single-cycle ops, sign fix-up and flags.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle after accept, result_lo 0x80000000, ovf 1, zero 0.
- slt a=0xFFFFFFFF b=1 -> result_lo 1; sltu on the same operands -> 0; sub 0x80000000 - 1 -> 0x7FFFFFFF, ovf 1.
- mult -3 * 5 -> out_valid exactly 34 cycles after accept, hi 0xFFFFFFFF, lo 0xFFFFFFF1; multu 0xFFFFFFFF * 2 -> hi 0x00000001, lo 0xFFFFFFFE.
- div -7 / 2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF, latency 34; divu 7 / 0 -> latency 1, div_by_zero 1, lo 0xFFFFFFFF, hi 7.
- Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready 0; then out_ready = 1 with the next in_valid -> accepted on the following cycle. Repeat the mult case with WIDTH=8: -3 * 5 -> hi 0xFF, lo 0xF1, latency 10.
- Assert rst_n low in ITER cycle 10 of a mult -> all outputs 0 and in_ready 1 while in reset. After release, add 2 + 3 -> 5, with no stale result emitted.
